vnu_param_serial: RTL and testbench
===================================

// Module: vnu_param_serial
// PURPOSE
//  Parametrised LDPC variable-node unit for any column degree DV. Replaces fixed-degree VNUs with one block.
//  Accumulates channel LLR plus DV check-to-variable messages serially, one per cycle, at extended width.
//  Emits saturated posterior V and DV extrinsic messages V2C_i = sat(V_full - C2V_i).
//  Sits between the C2V routing network and CNU inputs; sequenced by the decoder controller via init/start/done.
// PARAMETERS
//  QW  6  message/LLR width, two's complement
//  DV  3  variable-node degree (number of C2V/V2C channels), 1..16
//  AW  QW+$clog2(DV+1)  internal accumulator width (localparam, not overridable)
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      reset, asynchronous, active-low
//  init      in   1      1-cycle pulse: load channel LLR, start new codeword
//  start     in   1      1-cycle pulse: begin one variable-node update
//  l_in      in   QW     channel LLR, signed
//  c2v_flat  in   DV*QW  C2V messages, channel i at [i*QW +: QW], signed
//  v2c_flat  out  DV*QW  V2C messages, registered, same packing
//  v_out     out  QW     posterior LLR, registered, saturated
//  busy      out  1      high in ACC and UPD states
//  done      out  1      1-cycle pulse, outputs valid for new iteration
//  hard_bit  out  1      only with VNU_HARD_DEC_EN: sign of posterior
//  hd_flip   out  1      only with VNU_HARD_DEC_EN: hard_bit changed on this update
// BEHAVIOUR
//  Reset: all v2c=0, v_out=0, busy=0, done=0, state IDLE, acc=0, idx=0; hard_bit=0, hd_flip=0.
//  States: IDLE -> ACC -> UPD -> IDLE.
//  IDLE + start: acc<=sext(l_in), idx<=0, ->ACC.
//  ACC: acc<=acc+sext(c2v[idx]), idx++. Leave after DV adds (idx==DV-1): ->UPD.
//  UPD: v2c[i]<=sat(acc-sext(c2v[i])) for all i; v_out<=sat(acc); done<=1; ->IDLE.
//  Latency: start sampled at edge 0; v2c/v_out/done update at edge DV+1; done high 1 cycle only.
//  l_in, c2v_flat are held stable by the controller from the start edge through the done edge.
//  Full-width add: subtract in AW+1 bits, no wrap anywhere.
//  sat(x): clamp to symmetric range [-(2^(QW-1)-1), +(2^(QW-1)-1)], i.e. [-31,+31] for QW=6.
//  Input -2^(QW-1) is accepted and used as-is.
//  init (any state, highest priority):
//   - all v2c<=l_in, v_out<=l_in (unsaturated copy); state->IDLE; busy=0; done=0.
//   - An in-flight update is aborted; no done is issued.
//  start while busy: ignored. start and init in the same cycle: init wins, start is dropped.
//  Async reset mid-ACC/UPD: immediate return to the reset values; no done is issued.
// CONFIGURATION
//  `VNU_HARD_DEC_EN defined:
//   - hard_bit and hd_flip ports exist.
//   - In UPD: hard_bit<=acc[AW-1]; hd_flip<=(acc[AW-1]!=hard_bit); hd_flip is 0 in all other cycles.
//   - init sets hard_bit<=l_in[QW-1], hd_flip<=0.
//  Not defined: both ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package ldpc_pkg:
//   - QW default constant.
//   - clog2 helper.
//   - vnu_state_t encoding (IDLE=0, ACC=1, UPD=2).
//   - SAT_MAX/SAT_MIN derivation from QW.
//  Sub-module vnu_sat (combinational, IW->QW symmetric saturator).
//   - Instantiated DV+1 times: DV for V2C, 1 for V.
//  C2V mux indexed by idx; no per-channel adders.
// TESTING (QW=6, DV=3 unless noted)
//  1. Nominal: l=10, c2v=5,7,-3; start at edge 0 -> done at edge 4 only; v_out=19; v2c=14,12,22.
//  2. Saturation: l=31, c2v=31,31,31 -> v_out=31, v2c all 31.
//     l=-32, c2v=-32,-32,-32 -> v_out=-31, v2c all -31.
//  3. init: init with l=-7 -> v2c all -7, v_out=-7, done=0.
//     init asserted during ACC (edge 2) -> IDLE, busy=0, no done pulse.
//  4. Handshake: start re-pulsed at edges 1..3 -> ignored, single done at edge 4.
//     init+start in the same cycle -> init only.
//  5. Reset: rst low mid-ACC -> all outputs 0 immediately.
//     Next start runs a full DV+1 cycles.
//  6. `VNU_HARD_DEC_EN, DV=1: init l=5 (hard_bit=0); c2v=-12 -> v_out=-7, v2c=5, hard_bit=1, hd_flip=1 for one cycle.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions: default message width, VNU state encoding, saturation bounds.
package ldpc_pkg;
    localparam int QW_DEF = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        UPD  = 2'd2
    } vnu_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    // Symmetric range keeps negation of any saturated message representable.
    function automatic int sat_max(input int qw);
        return (1 << (qw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int qw);
        return -((1 << (qw - 1)) - 1);
    endfunction
endpackage

// File: rtl/vnu_sat.sv
// Symmetric saturator from IW-bit signed value down to QW bits.
// Combinational, zero latency; no flow control.
module vnu_sat
    import ldpc_pkg::*;
#(
    parameter int IW = 9,
    parameter int QW = QW_DEF
) (
    input  logic signed [IW-1:0] x_i,
    output logic signed [QW-1:0] y_o
);
    localparam logic signed [IW-1:0] MAX_W = IW'(sat_max(QW));
    localparam logic signed [IW-1:0] MIN_W = IW'(sat_min(QW));

    always_comb begin
        if (x_i > MAX_W) begin
            y_o = MAX_W[QW-1:0];
        end else if (x_i < MIN_W) begin
            y_o = MIN_W[QW-1:0];
        end else begin
            y_o = x_i[QW-1:0];
        end
    end
endmodule

// File: rtl/vnu_param_serial.sv
// LDPC variable-node unit of degree DV, serial C2V accumulation; VNU_HARD_DEC_EN adds hard_bit/hd_flip.
// Latency DV+1 cycles start->done; no backpressure: start ignored while busy, init aborts any update.
module vnu_param_serial
    import ldpc_pkg::*;
#(
    parameter int QW = QW_DEF,
    parameter int DV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             start,
    input  logic [QW-1:0]    l_in,
    input  logic [DV*QW-1:0] c2v_flat,
    output logic [DV*QW-1:0] v2c_flat,
    output logic [QW-1:0]    v_out,
    output logic             busy,
    output logic             done
`ifdef VNU_HARD_DEC_EN
    ,
    output logic             hard_bit,
    output logic             hd_flip
`endif
);
    localparam int AW   = QW + clog2(DV + 1);
    localparam int IDXW = (DV > 1) ? clog2(DV) : 1;

    vnu_state_t           state_q;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;
    logic [IDXW-1:0]      idx_q;
    logic [QW-1:0]        v2c_q [DV];
    logic [QW-1:0]        v_out_q;
    logic                 done_q;

    logic [QW-1:0]        c2v [DV];
    logic signed [AW:0]   ext_diff [DV];
    logic [QW-1:0]        v2c_sat [DV];
    logic [QW-1:0]        v_sat;
    logic signed [AW-1:0] l_ext;
    logic signed [AW-1:0] c2v_sel_ext;

`ifdef VNU_HARD_DEC_EN
    logic hard_q;
    logic flip_q;

    assign hard_bit = hard_q;
    assign hd_flip  = flip_q;
`endif

    assign l_ext       = {{(AW-QW){l_in[QW-1]}}, l_in};
    assign c2v_sel_ext = {{(AW-QW){c2v[idx_q][QW-1]}}, c2v[idx_q]};
    assign acc_d       = acc_q + c2v_sel_ext;

    // Extrinsic subtraction carries one extra bit so it can never wrap.
    for (genvar i = 0; i < DV; i++) begin : g_ch
        assign c2v[i]      = c2v_flat[i*QW +: QW];
        assign ext_diff[i] = {acc_q[AW-1], acc_q} - {{(AW+1-QW){c2v[i][QW-1]}}, c2v[i]};
        assign v2c_flat[i*QW +: QW] = v2c_q[i];

        vnu_sat #(.IW(AW + 1), .QW(QW)) u_sat_v2c (
            .x_i (ext_diff[i]),
            .y_o (v2c_sat[i])
        );
    end

    vnu_sat #(.IW(AW), .QW(QW)) u_sat_v (
        .x_i (acc_q),
        .y_o (v_sat)
    );

    assign v_out = v_out_q;
    assign done  = done_q;
    assign busy  = (state_q == ACC) || (state_q == UPD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            v_out_q <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < DV; i++) v2c_q[i] <= '0;
`ifdef VNU_HARD_DEC_EN
            hard_q  <= 1'b0;
            flip_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef VNU_HARD_DEC_EN
            flip_q <= 1'b0;
`endif
            if (init) begin
                state_q <= IDLE;
                v_out_q <= l_in;
                for (int i = 0; i < DV; i++) v2c_q[i] <= l_in;
`ifdef VNU_HARD_DEC_EN
                hard_q  <= l_in[QW-1];
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            acc_q   <= l_ext;
                            idx_q   <= '0;
                            state_q <= ACC;
                        end
                    end
                    ACC: begin
                        acc_q <= acc_d;
                        if (idx_q == IDXW'(DV - 1)) begin
                            idx_q   <= '0;
                            state_q <= UPD;
                        end else begin
                            idx_q <= idx_q + IDXW'(1);
                        end
                    end
                    UPD: begin
                        for (int i = 0; i < DV; i++) v2c_q[i] <= v2c_sat[i];
                        v_out_q <= v_sat;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
`ifdef VNU_HARD_DEC_EN
                        hard_q  <= acc_q[AW-1];
                        flip_q  <= (acc_q[AW-1] != hard_q);
`endif
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vnu_param_serial.sv
// Bench for vnu_param_serial: DV=3 main instance plus a DV=1 instance, reference model on plain integers.
module tb_vnu_param_serial;
    localparam int QW   = 6;
    localparam int DV   = 3;
    localparam int SMAX = (1 << (QW - 1)) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             init, start;
    logic [QW-1:0]    l_in;
    logic [DV*QW-1:0] c2v_flat;
    logic [DV*QW-1:0] v2c_flat;
    logic [QW-1:0]    v_out;
    logic             busy, done;

    logic             init1, start1;
    logic [QW-1:0]    l1, c1, v2c1, v1;
    logic             busy1, done1;
`ifdef VNU_HARD_DEC_EN
    logic             hard_bit, hd_flip, hard1, flip1;
`endif

    int errors = 0;
    int checks = 0;

    int            cur_l;
    int            cur_c [DV];
    logic [QW-1:0] exp_v;
    logic [QW-1:0] exp_v2c [DV];
    logic          exp_hard;
    logic          exp_flip;

    always #5 clk = ~clk;

    vnu_param_serial #(.QW(QW), .DV(DV)) dut (
        .clk      (clk),
        .rst      (rst),
        .init     (init),
        .start    (start),
        .l_in     (l_in),
        .c2v_flat (c2v_flat),
        .v2c_flat (v2c_flat),
        .v_out    (v_out),
        .busy     (busy),
        .done     (done)
`ifdef VNU_HARD_DEC_EN
        ,
        .hard_bit (hard_bit),
        .hd_flip  (hd_flip)
`endif
    );

    vnu_param_serial #(.QW(QW), .DV(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .init     (init1),
        .start    (start1),
        .l_in     (l1),
        .c2v_flat (c1),
        .v2c_flat (v2c1),
        .v_out    (v1),
        .busy     (busy1),
        .done     (done1)
`ifdef VNU_HARD_DEC_EN
        ,
        .hard_bit (hard1),
        .hd_flip  (flip1)
`endif
    );

    function automatic int sat(input int x);
        if (x > SMAX) return SMAX;
        if (x < -SMAX) return -SMAX;
        return x;
    endfunction

    function automatic int rnd_val();
        int pick;
        pick = int'($urandom_range(7));
        if (pick == 0) return -32;
        if (pick == 1) return 31;
        if (pick == 2) return -31;
        return int'($urandom_range(63)) - 32;
    endfunction

    task automatic drive_inputs();
        l_in = cur_l[QW-1:0];
        for (int i = 0; i < DV; i++) c2v_flat[i*QW +: QW] = cur_c[i][QW-1:0];
    endtask

    task automatic predict_update();
        int sum;
        sum = cur_l;
        for (int i = 0; i < DV; i++) sum += cur_c[i];
        exp_v = QW'(sat(sum));
        for (int i = 0; i < DV; i++) exp_v2c[i] = QW'(sat(sum - cur_c[i]));
        exp_flip = (sum < 0) != exp_hard;
        exp_hard = (sum < 0);
    endtask

    task automatic predict_init();
        exp_v = cur_l[QW-1:0];
        for (int i = 0; i < DV; i++) exp_v2c[i] = cur_l[QW-1:0];
        exp_hard = (cur_l < 0);
        exp_flip = 1'b0;
    endtask

    // Runs one update from #1 after an edge; done must appear exactly DV+1 edges after start.
    task automatic do_update(input string tag, input bit repulse);
        drive_inputs();
        start = 1'b1;
        @(posedge clk); #1;
        if (!repulse) start = 1'b0;
        for (int k = 1; k <= DV; k++) begin
            @(posedge clk); #1;
            if (k == DV) start = 1'b0;
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s edge%0d: done=%b busy=%b expected done=0 busy=1", tag, k, done, busy);
            end
            checks++;
            if (v_out !== exp_v) begin
                errors++;
                $display("FAIL %s hold edge%0d: v_out=%0d expected %0d", tag, k, $signed(v_out), $signed(exp_v));
            end
`ifdef VNU_HARD_DEC_EN
            checks++;
            if (hd_flip !== 1'b0) begin
                errors++;
                $display("FAIL %s flip edge%0d: hd_flip=%b expected 0", tag, k, hd_flip);
            end
`endif
        end
        predict_update();
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done edge: done=%b busy=%b expected done=1 busy=0", tag, done, busy);
        end
        checks++;
        if (v_out !== exp_v) begin
            errors++;
            $display("FAIL %s v_out: got %0d expected %0d", tag, $signed(v_out), $signed(exp_v));
        end
        for (int i = 0; i < DV; i++) begin
            checks++;
            if (v2c_flat[i*QW +: QW] !== exp_v2c[i]) begin
                errors++;
                $display("FAIL %s v2c[%0d]: got %0d expected %0d", tag, i,
                         $signed(v2c_flat[i*QW +: QW]), $signed(exp_v2c[i]));
            end
        end
`ifdef VNU_HARD_DEC_EN
        checks++;
        if (hard_bit !== exp_hard || hd_flip !== exp_flip) begin
            errors++;
            $display("FAIL %s hard: hard_bit=%b hd_flip=%b expected %b %b", tag, hard_bit, hd_flip, exp_hard, exp_flip);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b0; init = 1'b0; start = 1'b0; l_in = '0; c2v_flat = '0;
        init1 = 1'b0; start1 = 1'b0; l1 = '0; c1 = '0;
        #12;
        checks++;
        if (v_out !== '0 || v2c_flat !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: v_out=%h v2c=%h busy=%b done=%b expected all 0", v_out, v2c_flat, busy, done);
        end
`ifdef VNU_HARD_DEC_EN
        checks++;
        if (hard_bit !== 1'b0 || hd_flip !== 1'b0) begin
            errors++;
            $display("FAIL reset hard: hard_bit=%b hd_flip=%b expected 0 0", hard_bit, hd_flip);
        end
`endif
        exp_v = '0; exp_hard = 1'b0; exp_flip = 1'b0;
        for (int i = 0; i < DV; i++) exp_v2c[i] = '0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_nominal();
        cur_l = 10; cur_c[0] = 5; cur_c[1] = 7; cur_c[2] = -3;
        do_update("nominal", 1'b0);
        checks++;
        if (v_out !== 6'd19 || v2c_flat !== {6'd22, 6'd12, 6'd14}) begin
            errors++;
            $display("FAIL nominal const: v_out=%0d v2c=%h expected 19 and %h", $signed(v_out), v2c_flat,
                     {6'd22, 6'd12, 6'd14});
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL nominal pulse: done=%b one cycle later, expected 0", done);
        end
    endtask

    task automatic test_saturation();
        logic [QW-1:0] neg31;
        neg31 = 6'b100001;
        cur_l = 31; for (int i = 0; i < DV; i++) cur_c[i] = 31;
        do_update("sat_pos", 1'b0);
        checks++;
        if (v_out !== 6'd31 || v2c_flat !== {3{6'd31}}) begin
            errors++;
            $display("FAIL sat_pos const: v_out=%0d v2c=%h expected 31 all", $signed(v_out), v2c_flat);
        end
        cur_l = -32; for (int i = 0; i < DV; i++) cur_c[i] = -32;
        do_update("sat_neg", 1'b0);
        checks++;
        if (v_out !== neg31 || v2c_flat !== {3{neg31}}) begin
            errors++;
            $display("FAIL sat_neg const: v_out=%0d v2c=%h expected -31 all", $signed(v_out), v2c_flat);
        end
    endtask

    task automatic test_init();
        cur_l = -7;
        l_in = cur_l[QW-1:0];
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        predict_init();
        checks++;
        if (v_out !== 6'h39 || v2c_flat !== {3{6'h39}} || done !== 1'b0) begin
            errors++;
            $display("FAIL init: v_out=%0d v2c=%h done=%b expected -7 all, done 0", $signed(v_out), v2c_flat, done);
        end
        // abort during ACC: init sampled at edge 2
        cur_l = 9; cur_c[0] = 20; cur_c[1] = -4; cur_c[2] = 6;
        drive_inputs();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        init = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort pre: busy=%b expected 1", busy);
        end
        @(posedge clk); #1;
        init = 1'b0;
        predict_init();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || v_out !== exp_v || v2c_flat !== {3{exp_v}}) begin
            errors++;
            $display("FAIL abort: busy=%b done=%b v_out=%0d v2c=%h expected 0 0 9 all", busy, done, $signed(v_out), v2c_flat);
        end
        for (int k = 0; k < DV + 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort tail%0d: done=%b busy=%b expected 0 0", k, done, busy);
            end
        end
    endtask

    task automatic test_handshake();
        cur_l = -11; cur_c[0] = 4; cur_c[1] = -20; cur_c[2] = 13;
        do_update("repulse", 1'b1);
        for (int k = 0; k < DV + 1; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL repulse tail%0d: done=%b busy=%b expected 0 0", k, done, busy);
            end
        end
        cur_l = -3; cur_c[0] = 8; cur_c[1] = 8; cur_c[2] = 8;
        drive_inputs();
        init = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        init = 1'b0; start = 1'b0;
        predict_init();
        checks++;
        if (busy !== 1'b0 || v_out !== exp_v || v2c_flat !== {3{exp_v}}) begin
            errors++;
            $display("FAIL init_start: busy=%b v_out=%0d v2c=%h expected 0 -3 all", busy, $signed(v_out), v2c_flat);
        end
        for (int k = 0; k < DV + 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL init_start tail%0d: done=%b busy=%b expected 0 0", k, done, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        cur_l = 12; cur_c[0] = 1; cur_c[1] = 2; cur_c[2] = 3;
        drive_inputs();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        checks++;
        if (v_out !== '0 || v2c_flat !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: v_out=%h v2c=%h busy=%b done=%b expected all 0", v_out, v2c_flat, busy, done);
        end
        exp_v = '0; exp_hard = 1'b0; exp_flip = 1'b0;
        for (int i = 0; i < DV; i++) exp_v2c[i] = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        do_update("after_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            cur_l = rnd_val();
            for (int i = 0; i < DV; i++) cur_c[i] = rnd_val();
            if ($urandom_range(5) == 0) begin
                l_in = cur_l[QW-1:0];
                init = 1'b1;
                @(posedge clk); #1;
                init = 1'b0;
                predict_init();
                checks++;
                if (v_out !== exp_v || v2c_flat !== {3{exp_v}} || done !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_init%0d: v_out=%0d v2c=%h done=%b expected %0d all", n,
                             $signed(v_out), v2c_flat, done, $signed(exp_v));
                end
            end else begin
                do_update($sformatf("rand%0d", n), 1'b0);
            end
        end
    endtask

    task automatic test_dv1();
        l1 = 6'd5;
        init1 = 1'b1;
        @(posedge clk); #1;
        init1 = 1'b0;
        checks++;
        if (v1 !== 6'd5 || v2c1 !== 6'd5) begin
            errors++;
            $display("FAIL dv1 init: v_out=%0d v2c=%0d expected 5 5", $signed(v1), $signed(v2c1));
        end
`ifdef VNU_HARD_DEC_EN
        checks++;
        if (hard1 !== 1'b0) begin
            errors++;
            $display("FAIL dv1 init hard: hard_bit=%b expected 0", hard1);
        end
`endif
        c1 = 6'b110100;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL dv1 edge1: done=%b busy=%b expected 0 1", done1, busy1);
        end
        @(posedge clk); #1;
        checks++;
        if (done1 !== 1'b1 || v1 !== 6'h39 || v2c1 !== 6'd5) begin
            errors++;
            $display("FAIL dv1 result: done=%b v_out=%0d v2c=%0d expected 1 -7 5", done1, $signed(v1), $signed(v2c1));
        end
`ifdef VNU_HARD_DEC_EN
        checks++;
        if (hard1 !== 1'b1 || flip1 !== 1'b1) begin
            errors++;
            $display("FAIL dv1 hard: hard_bit=%b hd_flip=%b expected 1 1", hard1, flip1);
        end
`endif
        @(posedge clk); #1;
        checks++;
        if (done1 !== 1'b0) begin
            errors++;
            $display("FAIL dv1 pulse: done=%b expected 0", done1);
        end
`ifdef VNU_HARD_DEC_EN
        checks++;
        if (flip1 !== 1'b0 || hard1 !== 1'b1) begin
            errors++;
            $display("FAIL dv1 flip pulse: hd_flip=%b hard_bit=%b expected 0 1", flip1, hard1);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_saturation();
        test_init();
        test_handshake();
        test_reset_mid();
        test_back_to_back();
        test_dv1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
